// File: rtl/decodificador_pwm.sv
// decodificador_pwm: receiver side of the servo PWM link.
// Synchronizes pwm_in, measures high time and rise-to-rise period in clock
// cycles, decodes the width back to the 2-bit posicao code, and flags missing
// signal (sem_sinal) and widths outside every tolerance band (erro_pulso).
module decodificador_pwm #(
    parameter int T_1MS   = 50_000,
    parameter int T_15MS  = 75_000,
    parameter int T_2MS   = 100_000,
    parameter int TOL     = 2_500,
    parameter int TIMEOUT = 1_250_000,
    parameter int N       = 21
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         pwm_in,
    output logic [1:0]   posicao,
    output logic [N-1:0] largura,
    output logic [N-1:0] periodo,
    output logic         valido,
    output logic         erro_pulso,
    output logic         sem_sinal
);

    typedef enum logic [1:0] {ESPERA, ALTO, BAIXO} estado_t;

    localparam logic [N-1:0] UM     = N'(1);
    // Timeout fires on the cycle the idle count would reach TIMEOUT.
    localparam logic [N-1:0] LIMITE = N'(TIMEOUT - 1);

    estado_t        estado, prox_estado;
    logic           s1, s2, s3;
    logic           sobe, desce, esgotado;
    logic [N-1:0]   cnt_alto, cnt_alto_prox;
    logic [N-1:0]   cnt_per, cnt_per_prox;
    logic [N-1:0]   ocioso, ocioso_prox;
    logic [N-1:0]   largura_tmp, largura_tmp_prox;
    logic [1:0]     posicao_prox;
    logic [N-1:0]   largura_prox, periodo_prox;
    logic           valido_prox, erro_prox, sem_prox;
    logic [2:0]     decod;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [N-1:0] sat_inc(input logic [N-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Returns {match, code}; bands are inclusive on both ends.
    function automatic logic [2:0] decodifica(input logic [N-1:0] w);
        int wi;
        wi = int'(w);
        if (wi >= T_1MS - TOL && wi <= T_1MS + TOL)
            return 3'b101;
        if (wi >= T_15MS - TOL && wi <= T_15MS + TOL)
            return 3'b110;
        if (wi >= T_2MS - TOL && wi <= T_2MS + TOL)
            return 3'b111;
        return 3'b000;
    endfunction

    assign sobe     = s2 & ~s3;
    assign desce    = ~s2 & s3;
    // A rise in the same cycle always beats the timeout.
    assign esgotado = ~sobe && (ocioso >= LIMITE);
    assign decod    = decodifica(largura_tmp);

    // Next-state and next-output logic of the measurement FSM.
    always_comb begin
        prox_estado      = estado;
        cnt_alto_prox    = cnt_alto;
        cnt_per_prox     = cnt_per;
        largura_tmp_prox = largura_tmp;
        posicao_prox     = posicao;
        largura_prox     = largura;
        periodo_prox     = periodo;
        valido_prox      = 1'b0;
        erro_prox        = 1'b0;
        sem_prox         = sem_sinal;
        ocioso_prox      = sobe ? '0 : sat_inc(ocioso);

        if (sobe)
            sem_prox = 1'b0;

        case (estado)
            ESPERA: begin
                if (sobe) begin
                    prox_estado   = ALTO;
                    cnt_alto_prox = UM;
                    cnt_per_prox  = UM;
                end
            end
            ALTO: begin
                cnt_alto_prox = sat_inc(cnt_alto);
                cnt_per_prox  = sat_inc(cnt_per);
                if (desce) begin
                    prox_estado      = BAIXO;
                    largura_tmp_prox = cnt_alto;
                end
            end
            BAIXO: begin
                cnt_per_prox = sat_inc(cnt_per);
                if (sobe) begin
                    // Commit the completed pulse and start the next one.
                    largura_prox  = largura_tmp;
                    periodo_prox  = cnt_per;
                    valido_prox   = 1'b1;
                    if (decod[2])
                        posicao_prox = decod[1:0];
                    else
                        erro_prox = 1'b1;
                    prox_estado   = ALTO;
                    cnt_alto_prox = UM;
                    cnt_per_prox  = UM;
                end
            end
            default: prox_estado = ESPERA;
        endcase

        // Flat-low and stuck-high both end up here.
        if (esgotado) begin
            sem_prox     = 1'b1;
            posicao_prox = 2'b00;
            prox_estado  = ESPERA;
        end
    end

    // State, synchronizer and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= ESPERA;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            cnt_alto    <= '0;
            cnt_per     <= '0;
            ocioso      <= '0;
            largura_tmp <= '0;
            posicao     <= 2'b00;
            largura     <= '0;
            periodo     <= '0;
            valido      <= 1'b0;
            erro_pulso  <= 1'b0;
            sem_sinal   <= 1'b0;
        end else begin
            estado      <= prox_estado;
            s1          <= pwm_in;
            s2          <= s1;
            s3          <= s2;
            cnt_alto    <= cnt_alto_prox;
            cnt_per     <= cnt_per_prox;
            ocioso      <= ocioso_prox;
            largura_tmp <= largura_tmp_prox;
            posicao     <= posicao_prox;
            largura     <= largura_prox;
            periodo     <= periodo_prox;
            valido      <= valido_prox;
            erro_pulso  <= erro_prox;
            sem_sinal   <= sem_prox;
        end
    end

endmodule
